mem_spi_streamer: RTL and testbench

Frame streamer directly downstream of the memory chip. On a start request it reads every memory word in address order, presenting `CS_bar`, `WE_bar` and `Address` to the memory. It serializes each returned `DataOut` word MSB-first onto a mode-0 SPI link to the OLED panel. It is the only read master of the frame memory while busy.

---
 rtl/mem_spi_streamer_pkg.sv | 6 +
 rtl/mem_spi_streamer_spi_shifter.sv | 53 +++++
 rtl/mem_spi_streamer.sv | 74 +++++++
 tb/tb_mem_spi_streamer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mem_spi_streamer_pkg.sv
// oled_pkg: frame streamer state type and SPI idle levels shared by the streamer and its shifter.
package oled_pkg;
   typedef enum logic [2:0] {IDLE, ADDR, LOAD, SHIFT, DONE} stream_state_t;
   localparam logic SCLK_IDLE = 1'b0;
   localparam logic CS_IDLE = 1'b1;
endpackage

// File: rtl/mem_spi_streamer_spi_shifter.sv
// spi_shifter: mode-0 SPI serializer, MSB first, CLK_DIV clk cycles per SCLK half-period.
module spi_shifter
   import oled_pkg::*;
#(
   parameter int WORD_SIZE = 8,
   parameter int CLK_DIV = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [WORD_SIZE-1:0] word,
   output logic                 sclk,
   output logic                 mosi,
   output logic                 last_bit_done
);
   localparam int DW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(WORD_SIZE + 1);
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_MAX = BW'(WORD_SIZE - 1);
   logic [WORD_SIZE-1:0] sr;
   logic [DW-1:0] div;
   logic [BW-1:0] bit_cnt;
   logic active, half_end;
   assign half_end = active && div == DIV_MAX;
   assign last_bit_done = half_end && sclk && bit_cnt == BIT_MAX;
   assign mosi = sr[WORD_SIZE-1];
   // The next bit is exposed by shifting on each falling SCLK edge, so mosi only moves while sclk is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr <= '0;
         div <= '0;
         bit_cnt <= '0;
         active <= 1'b0;
         sclk <= SCLK_IDLE;
      end else if (load) begin
         sr <= word;
         div <= '0;
         bit_cnt <= '0;
         active <= 1'b1;
         sclk <= SCLK_IDLE;
      end else if (active) begin
         div <= half_end ? '0 : div + 1'b1;
         if (half_end) begin
            sclk <= ~sclk;
            if (sclk) begin
               sr <= sr << 1;
               bit_cnt <= bit_cnt + 1'b1;
               active <= !last_bit_done;
            end
         end
      end
   end
endmodule

// File: rtl/mem_spi_streamer.sv
// mem_spi_streamer: reads every frame-memory word in address order and streams it MSB-first over mode-0 SPI.
// Define STREAM_LOOP_EN to restart the frame back-to-back while start stays high.
module mem_spi_streamer
   import oled_pkg::*;
#(
   parameter int nCells = 8,
   parameter int WORD_SIZE = 8,
   parameter int CLK_DIV = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      CS_bar,
   output logic                      WE_bar,
   output logic [$clog2(nCells)-1:0] Address,
   input  logic [WORD_SIZE-1:0]      DataOut,
   output logic                      sclk,
   output logic                      mosi,
   output logic                      oled_cs_n
);
   localparam int AW = $clog2(nCells);
   localparam logic [AW-1:0] LAST = AW'(nCells - 1);
   stream_state_t state, next;
   logic [AW-1:0] cnt;
   logic last_bit_done, in_frame, mem_cyc;
   spi_shifter #(.WORD_SIZE(WORD_SIZE), .CLK_DIV(CLK_DIV)) u_shifter (
      .clk(clk),
      .rst(rst),
      .load(state == LOAD),
      .word(DataOut),
      .sclk(sclk),
      .mosi(mosi),
      .last_bit_done(last_bit_done)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         state <= next;
         if (state == SHIFT && last_bit_done) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end
   always_comb begin
      next = state;
      case (state)
         IDLE:  next = start ? ADDR : IDLE;
         ADDR:  next = LOAD;
         LOAD:  next = SHIFT;
         SHIFT: next = !last_bit_done ? SHIFT : (cnt == LAST ? DONE : ADDR);
`ifdef STREAM_LOOP_EN
         DONE:  next = start ? ADDR : IDLE;
`else
         DONE:  next = IDLE;
`endif
         default: next = IDLE;
      endcase
   end
   assign mem_cyc = state inside {ADDR, LOAD};
   assign in_frame = state inside {ADDR, LOAD, SHIFT};
   assign busy = state != IDLE;
   assign done = state == DONE;
   assign CS_bar = mem_cyc ? 1'b0 : CS_IDLE;
   assign WE_bar = 1'b1;
   assign Address = mem_cyc ? cnt : '0;
`ifdef STREAM_LOOP_EN
   // Keep the panel selected across the frame boundary when another frame follows immediately.
   assign oled_cs_n = (in_frame || (done && start)) ? 1'b0 : CS_IDLE;
`else
   assign oled_cs_n = in_frame ? 1'b0 : CS_IDLE;
`endif
endmodule

// File: tb/tb_mem_spi_streamer.sv
// tb_mem_spi_streamer: random frames checked every cycle against a frame-position model of the streamer.
module tb_mem_spi_streamer;
   localparam int N = 5, WS = 8, CD = 2;
   localparam int P = 2 + 2 * CD * WS;
   localparam int FL = N * P;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic busy, done, CS_bar, WE_bar, sclk, mosi, oled_cs_n;
   logic [$clog2(N)-1:0] Address;
   logic [WS-1:0] DataOut = '0;
   logic [WS-1:0] mem [N];
   logic [63:0] bits = '0;
   int mt = -1;
   int tests = 0, fails = 0;
   int cyc = 0, nrise = 0, ndone = 0, done_cyc = -1;
   int w, r, k;
   logic ex_mem, ex_sh;

   mem_spi_streamer #(.nCells(N), .WORD_SIZE(WS), .CLK_DIV(CD)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .CS_bar(CS_bar), .WE_bar(WE_bar), .Address(Address), .DataOut(DataOut),
      .sclk(sclk), .mosi(mosi), .oled_cs_n(oled_cs_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // memory with one-cycle read latency
   always @(posedge clk) if (!CS_bar) DataOut <= mem[Address];
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge sclk) begin
      bits <= {bits[62:0], mosi};
      nrise <= nrise + 1;
   end

   // model: mt is the cycle index inside the current frame (0 = first ADDR, FL = DONE), -1 when idle
   always @(posedge clk or negedge rst)
      if (!rst) mt <= -1;
      else if (mt < 0) mt <= start ? 0 : -1;
      else mt <= (mt == FL) ? -1 : mt + 1;

   always @(negedge clk) if (rst) begin
      w = mt / P;
      r = mt % P;
      k = r - 2;
      ex_mem = mt >= 0 && mt < FL && r < 2;
      ex_sh = mt >= 0 && mt < FL && r >= 2;
      chk("busy", 64'(busy), 64'(mt >= 0));
      chk("done", 64'(done), 64'(mt == FL));
      chk("cs_bar", 64'(CS_bar), 64'(!ex_mem));
      chk("we_bar", 64'(WE_bar), 64'd1);
      chk("oled_cs_n", 64'(oled_cs_n), 64'(!(mt >= 0 && mt < FL)));
      chk("sclk", 64'(sclk), 64'(ex_sh && (k % (2 * CD)) >= CD));
      if (ex_mem) chk("address", 64'(Address), 64'(w));
      if (ex_sh) chk("mosi", 64'(mosi), 64'(mem[w][WS-1-k/(2*CD)]));
      if (done) begin
         ndone++;
         done_cyc = cyc;
      end
   end

   task automatic reset_vals(input string nm);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_done"}, 64'(done), 64'd0);
      chk({nm, "_cs_bar"}, 64'(CS_bar), 64'd1);
      chk({nm, "_we_bar"}, 64'(WE_bar), 64'd1);
      chk({nm, "_addr"}, 64'(Address), 64'd0);
      chk({nm, "_sclk"}, 64'(sclk), 64'd0);
      chk({nm, "_mosi"}, 64'(mosi), 64'd0);
      chk({nm, "_oled_cs_n"}, 64'(oled_cs_n), 64'd1);
   endtask

   // one frame from idle; extra_start re-pulses start mid-SHIFT, which must be ignored
   task automatic frame(input bit extra_start);
      int s;
      logic [63:0] exp_bits;
      exp_bits = '0;
      for (int i = 0; i < N; i++) exp_bits = {exp_bits[55:0], mem[i]};
      nrise = 0;
      ndone = 0;
      done_cyc = -1;
      @(negedge clk);
      start = 1'b1;
      s = cyc;
      @(negedge clk);
      start = 1'b0;
      if (extra_start) begin
         repeat ($urandom_range(P + 3, FL - 5)) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      while (cyc - s < FL + 4) @(negedge clk);
      chk("done_count", 64'(ndone), 64'd1);
      chk("done_cycle", 64'(done_cyc - s), 64'(FL + 1));
      chk("sclk_rises", 64'(nrise), 64'(N * WS));
      chk("bitstream", bits & 64'hFF_FFFF_FFFF, exp_bits);
   endtask

   initial begin
      #1 reset_vals("por");
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF; mem[3] = 8'h00; mem[4] = 8'h5A;
      frame(1'b0);
      chk("literal_stream", bits & 64'hFF_FFFF_FFFF, 64'hA5_3CFF_005A);
      chk("literal_done_cycle", 64'(done_cyc - (cyc - FL - 4)), 64'd171);
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < N; i++) mem[i] = WS'($urandom);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         frame(f[0]);
      end
      // start held high through DONE: a second frame follows from IDLE
      ndone = 0;
      @(negedge clk);
      start = 1'b1;
      repeat (FL + 4) @(negedge clk);
      start = 1'b0;
      repeat (FL + 6) @(negedge clk);
      chk("held_start_dones", 64'(ndone), 64'd2);
      // reset during word 2, bit 3
      ndone = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2 * P + 2 + 3 * 2 * CD + CD) @(negedge clk);
      chk("pre_reset_oled_cs", 64'(oled_cs_n), 64'd0);
      #2 rst = 1'b0;
      #1 reset_vals("midrst");
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      repeat (FL + 4) @(negedge clk);
      chk("midrst_no_done", 64'(ndone), 64'd0);
      for (int i = 0; i < N; i++) mem[i] = WS'($urandom);
      frame(1'b0);
      // reset at a random point of a random frame, then a clean frame
      for (int i = 0; i < N; i++) mem[i] = WS'($urandom);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat ($urandom_range(1, FL)) @(negedge clk);
      #3 rst = 1'b0;
      #1 reset_vals("rndrst");
      @(negedge clk);
      #2 rst = 1'b1;
      frame(1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
